lpddr2_avm_arbiter: RTL and testbench

Two-port Avalon-MM arbiter that shares the single LPDDR2 multi-port front-end (MPFE) port between two requesters, such as the CPU bus bridge and a frame/DMA reader. It sits in the `avm_clk` domain between the requesters and the MPFE slave. It grants only while the memory interface reports ready, alternates round-robin, and routes pipelined read data back to the issuing requester through an in-order tag FIFO.

---
 rtl/lpddr2_avm_arbiter_if.sv | 25 ++
 rtl/lpddr2_avm_arbiter.sv | 121 ++++++++++++
 tb/tb_lpddr2_avm_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lpddr2_avm_arbiter_if.sv
// Avalon-MM command/response bundle used for both requester ports and the MPFE port.
// master drives the command; slave drives waitrequest and the read response.
interface lpddr2_avm_arbiter_if #(
    parameter int ADDR_W = 27,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   address;
    logic                read;
    logic                write;
    logic [DATA_W-1:0]   writedata;
    logic [DATA_W/8-1:0] byteenable;
    logic                waitrequest;
    logic [DATA_W-1:0]   readdata;
    logic                readdatavalid;

    modport master (
        output address, read, write, writedata, byteenable,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/lpddr2_avm_arbiter.sv
// Round-robin arbiter sharing one LPDDR2 MPFE Avalon port between two requesters;
// an in-order tag FIFO steers pipelined read data back to the issuing requester.
module lpddr2_avm_arbiter #(
    parameter int ADDR_W    = 27,
    parameter int DATA_W    = 32,
    parameter int MAX_OUTST = 4
) (
    input  logic                 avm_clk,
    input  logic                 avm_rst_n,
    input  logic                 mem_ready,
    lpddr2_avm_arbiter_if.slave  s0,
    lpddr2_avm_arbiter_if.slave  s1,
    lpddr2_avm_arbiter_if.master m,
    output logic                 rd_err
);
    localparam int PTR_W = $clog2(MAX_OUTST);
    localparam int CNT_W = $clog2(MAX_OUTST) + 1;

    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

    state_t               state;
    logic                 rr;
    logic [MAX_OUTST-1:0] tags;
    logic [PTR_W-1:0]     wptr, rptr;
    logic [CNT_W-1:0]     count;
    logic                 full, empty, cmd0, cmd1, elig0, elig1;
    logic                 accept, push, pop;

    assign full   = (count == CNT_W'(MAX_OUTST));
    assign empty  = (count == '0);
    assign cmd0   = s0.read | s0.write;
    assign cmd1   = s1.read | s1.write;
    assign elig0  = s0.write | (s0.read & ~full);
    assign elig1  = s1.write | (s1.read & ~full);
    assign accept = (state != IDLE) & ~m.waitrequest & (m.read | m.write);
    assign push   = accept & m.read;
    assign pop    = m.readdatavalid & ~empty;

    always_ff @(posedge avm_clk or negedge avm_rst_n) begin
        if (!avm_rst_n) begin
            state <= IDLE;
            rr    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (mem_ready) begin
                    if (elig0 && (!elig1 || !rr)) state <= GNT0;
                    else if (elig1)               state <= GNT1;
                end
                // A dropped command is a protocol violation; release the grant without a push.
                GNT0: if (!cmd0) state <= IDLE;
                      else if (!m.waitrequest) begin
                          state <= IDLE;
                          rr    <= 1'b1;
                      end
                GNT1: if (!cmd1) state <= IDLE;
                      else if (!m.waitrequest) begin
                          state <= IDLE;
                          rr    <= 1'b0;
                      end
                default: state <= IDLE;
            endcase
        end
    end

    // Tag FIFO: one bit per outstanding read, 1 = requester 1.
    always_ff @(posedge avm_clk or negedge avm_rst_n) begin
        if (!avm_rst_n) begin
            tags   <= '0;
            wptr   <= '0;
            rptr   <= '0;
            count  <= '0;
            rd_err <= 1'b0;
        end else begin
            if (push) begin
                tags[wptr] <= (state == GNT1);
                wptr       <= wptr + PTR_W'(1);
            end
            if (pop) rptr <= rptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (m.readdatavalid && empty) rd_err <= 1'b1;
        end
    end

    always_comb begin
        m.address      = {ADDR_W{1'b0}};
        m.read         = 1'b0;
        m.write        = 1'b0;
        m.writedata    = {DATA_W{1'b0}};
        m.byteenable   = {(DATA_W/8){1'b0}};
        s0.waitrequest = 1'b1;
        s1.waitrequest = 1'b1;
        case (state)
            GNT0: begin
                m.address      = s0.address;
                m.read         = s0.read;
                m.write        = s0.write;
                m.writedata    = s0.writedata;
                m.byteenable   = s0.byteenable;
                s0.waitrequest = m.waitrequest;
            end
            GNT1: begin
                m.address      = s1.address;
                m.read         = s1.read;
                m.write        = s1.write;
                m.writedata    = s1.writedata;
                m.byteenable   = s1.byteenable;
                s1.waitrequest = m.waitrequest;
            end
            default: ;
        endcase
    end

    assign s0.readdata      = m.readdata;
    assign s1.readdata      = m.readdata;
    assign s0.readdatavalid = m.readdatavalid & ~empty & ~tags[rptr];
    assign s1.readdatavalid = m.readdatavalid & ~empty &  tags[rptr];
endmodule

// File: tb/tb_lpddr2_avm_arbiter.sv
// Scoreboard bench for lpddr2_avm_arbiter: directed requester traffic, an MPFE
// model returning reads after 5 cycles, and a monitor checking every transfer.
module tb_lpddr2_avm_arbiter;
    localparam int AW = 27;
    localparam int DW = 32;

    typedef struct packed {
        logic          port;
        logic          rd;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [3:0]    be;
    } cmd_t;

    typedef struct packed {
        logic          port;
        logic [DW-1:0] data;
    } rsp_t;

    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } pend_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic mem_ready = 1'b0;
    logic rd_err;
    logic hold = 1'b0;
    logic rel = 1'b0;
    logic inj = 1'b0;

    cmd_t  q0[$], q1[$], exp_cmd[$];
    rsp_t  exp_rsp[$];
    pend_t pend[$];
    int    acc_cyc[$];
    int    checks = 0;
    int    failures = 0;
    int    cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lpddr2_avm_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) s0 ();
    lpddr2_avm_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) s1 ();
    lpddr2_avm_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m ();

    lpddr2_avm_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_OUTST(4)) dut (
        .avm_clk   (clk),
        .avm_rst_n (rst_n),
        .mem_ready (mem_ready),
        .s0        (s0),
        .s1        (s1),
        .m         (m),
        .rd_err    (rd_err)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic cmd_t mk(input logic p, input logic rd, input logic [AW-1:0] a,
                                input logic [DW-1:0] d, input logic [3:0] be);
        cmd_t c;
        c.port = p; c.rd = rd; c.addr = a; c.data = d; c.be = be;
        return c;
    endfunction

    task automatic issue(input cmd_t c);
        if (c.port) q1.push_back(c);
        else        q0.push_back(c);
    endtask

    task automatic exp_r(input logic p, input logic [DW-1:0] d);
        rsp_t r;
        r.port = p; r.data = d;
        exp_rsp.push_back(r);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_cmd.size() + exp_rsp.size() + q0.size() + q1.size()) != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(name, exp_cmd.size() + exp_rsp.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    // Requester drivers: hold each command until it is seen accepted.
    initial begin
        logic acc0, acc1, busy0, busy1;
        cmd_t c;
        busy0 = 1'b0; busy1 = 1'b0;
        s0.read = 1'b0; s0.write = 1'b0; s0.address = '0; s0.writedata = '0; s0.byteenable = '0;
        s1.read = 1'b0; s1.write = 1'b0; s1.address = '0; s1.writedata = '0; s1.byteenable = '0;
        forever begin
            @(negedge clk);
            acc0 = (s0.read | s0.write) & ~s0.waitrequest;
            acc1 = (s1.read | s1.write) & ~s1.waitrequest;
            @(posedge clk);
            #1;
            if (acc0) begin s0.read = 1'b0; s0.write = 1'b0; busy0 = 1'b0; end
            if (acc1) begin s1.read = 1'b0; s1.write = 1'b0; busy1 = 1'b0; end
            if (!busy0 && q0.size() > 0) begin
                c = q0.pop_front();
                s0.read = c.rd; s0.write = ~c.rd; s0.address = c.addr;
                s0.writedata = c.data; s0.byteenable = c.be; busy0 = 1'b1;
            end
            if (!busy1 && q1.size() > 0) begin
                c = q1.pop_front();
                s1.read = c.rd; s1.write = ~c.rd; s1.address = c.addr;
                s1.writedata = c.data; s1.byteenable = c.be; busy1 = 1'b1;
            end
        end
    end

    // MPFE model: read data = DA7A_<addr[15:0]>, returned 5 cycles after acceptance.
    initial begin
        pend_t pe;
        m.readdatavalid = 1'b0;
        m.readdata = '0;
        forever begin
            @(negedge clk);
            if (rst_n && m.read && !m.waitrequest) begin
                pe.due  = cyc + 5;
                pe.data = 32'hDA7A_0000 | {16'h0, m.address[15:0]};
                pend.push_back(pe);
            end
            @(posedge clk);
            #1;
            m.readdatavalid = 1'b0;
            m.readdata = '0;
            if (inj) begin
                m.readdatavalid = 1'b1;
                m.readdata = 32'hBAD0_BAD0;
            end else if (pend.size() > 0 && (rel || (!hold && pend[0].due <= cyc))) begin
                m.readdatavalid = 1'b1;
                m.readdata = pend[0].data;
                pend.delete(0);
            end
        end
    end

    // Monitor: every MPFE acceptance and every requester read-valid is scored.
    always @(negedge clk) begin
        cmd_t act, e;
        rsp_t ra, re;
        if (rst_n) begin
            if ((m.read || m.write) && !m.waitrequest) begin
                acc_cyc.push_back(cyc);
                act = mk(s0.waitrequest, m.read, m.address, m.writedata, m.byteenable);
                chk("one_grant", {s0.waitrequest, s1.waitrequest, m.write}, {act.port, ~act.port, ~m.read});
                if (exp_cmd.size() == 0) chk("unexpected_cmd", act, 128'h0);
                else begin
                    e = exp_cmd.pop_front();
                    chk("cmd", act, e);
                end
            end
            if (s0.readdatavalid && s1.readdatavalid) chk("dual_rdv", 2'b11, 2'b00);
            if (s0.readdatavalid || s1.readdatavalid) begin
                ra.port = s1.readdatavalid;
                ra.data = s1.readdatavalid ? s1.readdata : s0.readdata;
                if (exp_rsp.size() == 0) chk("unexpected_rsp", ra, 128'h0);
                else begin
                    re = exp_rsp.pop_front();
                    chk("rsp", ra, re);
                end
            end
        end
    end

    initial begin
        int base, t;
        m.waitrequest = 1'b0;

        // Reset and gating: s0 read held while mem_ready is low.
        issue(mk(0, 1, 27'h100, 32'h0, 4'hF));
        exp_cmd.push_back(mk(0, 1, 27'h100, 32'h0, 4'hF));
        exp_r(0, 32'hDA7A_0100);
        repeat (3) @(negedge clk);
        chk("rst_wait0", s0.waitrequest, 1);
        chk("rst_wait1", s1.waitrequest, 1);
        chk("rst_mcmd", {m.read, m.write}, 0);
        chk("rst_rdv", {s0.readdatavalid, s1.readdatavalid}, 0);
        chk("rst_rderr", rd_err, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("gate_wait", s0.waitrequest, 1);
            chk("gate_mread", m.read, 0);
        end
        @(posedge clk); #1 mem_ready = 1'b1;
        @(negedge clk);
        chk("gate_pre", m.read, 0);
        @(negedge clk);
        chk("gate_mread_up", m.read, 1);
        wait_drain("gate_drain");

        // Round robin: rr points at s1 after the s0 read above.
        @(negedge clk);
        base = acc_cyc.size();
        issue(mk(0, 0, 27'h200, 32'hA000_0200, 4'hF));
        issue(mk(0, 0, 27'h201, 32'hA000_0201, 4'h3));
        issue(mk(1, 0, 27'h300, 32'hB000_0300, 4'hF));
        issue(mk(1, 0, 27'h301, 32'hB000_0301, 4'hC));
        exp_cmd.push_back(mk(1, 0, 27'h300, 32'hB000_0300, 4'hF));
        exp_cmd.push_back(mk(0, 0, 27'h200, 32'hA000_0200, 4'hF));
        exp_cmd.push_back(mk(1, 0, 27'h301, 32'hB000_0301, 4'hC));
        exp_cmd.push_back(mk(0, 0, 27'h201, 32'hA000_0201, 4'h3));
        wait_drain("rr_drain");
        chk("rr_count", acc_cyc.size() - base, 4);
        if (acc_cyc.size() - base >= 4)
            for (int i = 1; i < 4; i++) chk("rr_gap", acc_cyc[base+i] - acc_cyc[base+i-1], 2);

        // Read routing: A (s0), B (s1), C (s0).
        @(negedge clk);
        issue(mk(0, 1, 27'h010, 32'h0, 4'hF));
        exp_cmd.push_back(mk(0, 1, 27'h010, 32'h0, 4'hF));
        exp_cmd.push_back(mk(1, 1, 27'h020, 32'h0, 4'hF));
        exp_cmd.push_back(mk(0, 1, 27'h030, 32'h0, 4'hF));
        exp_r(0, 32'hDA7A_0010);
        exp_r(1, 32'hDA7A_0020);
        exp_r(0, 32'hDA7A_0030);
        @(negedge clk);
        issue(mk(1, 1, 27'h020, 32'h0, 4'hF));
        issue(mk(0, 1, 27'h030, 32'h0, 4'hF));
        wait_drain("route_drain");

        // Full FIFO: four reads fill it, the fifth stalls while an s1 write proceeds.
        hold = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            issue(mk(0, 1, 27'h040 + 27'(i), 32'h0, 4'hF));
            if (i < 4) exp_cmd.push_back(mk(0, 1, 27'h040 + 27'(i), 32'h0, 4'hF));
        end
        exp_r(0, 32'hDA7A_0040); exp_r(0, 32'hDA7A_0041); exp_r(0, 32'hDA7A_0042);
        exp_r(0, 32'hDA7A_0043); exp_r(0, 32'hDA7A_0044);
        repeat (14) @(negedge clk);
        chk("full_stall", {s0.waitrequest, m.read}, 2'b10);
        issue(mk(1, 0, 27'h350, 32'hB000_0350, 4'hF));
        exp_cmd.push_back(mk(1, 0, 27'h350, 32'hB000_0350, 4'hF));
        repeat (6) @(negedge clk);
        chk("full_wr_pass", exp_cmd.size(), 0);
        chk("full_stall_b", s0.waitrequest, 1);
        // One return frees a slot; a second return lands in the fifth read's grant cycle.
        exp_cmd.push_back(mk(0, 1, 27'h044, 32'h0, 4'hF));
        rel = 1'b1;
        @(negedge clk); rel = 1'b0;
        @(negedge clk); rel = 1'b1;
        @(negedge clk); rel = 1'b0;
        issue(mk(0, 1, 27'h045, 32'h0, 4'hF));
        issue(mk(0, 1, 27'h046, 32'h0, 4'hF));
        exp_cmd.push_back(mk(0, 1, 27'h045, 32'h0, 4'hF));
        exp_r(0, 32'hDA7A_0045); exp_r(0, 32'hDA7A_0046);
        repeat (12) @(negedge clk);
        chk("full_stall_c", {s0.waitrequest, m.read, exp_cmd.size()}, {2'b10, 32'd0});
        exp_cmd.push_back(mk(0, 1, 27'h046, 32'h0, 4'hF));
        hold = 1'b0;
        wait_drain("full_drain");

        // Waitrequest stall during GNT1.
        m.waitrequest = 1'b1;
        issue(mk(1, 0, 27'h360, 32'hB000_0360, 4'h5));
        exp_cmd.push_back(mk(1, 0, 27'h360, 32'hB000_0360, 4'h5));
        t = 0;
        while (!m.write && t < 20) begin @(negedge clk); t++; end
        chk("stall_grant", m.write, 1);
        for (int k = 0; k < 3; k++) begin
            chk("stall_wait", {s0.waitrequest, s1.waitrequest, m.write}, 3'b111);
            if (k < 2) @(negedge clk);
        end
        @(posedge clk); #1 m.waitrequest = 1'b0;
        @(negedge clk);
        chk("stall_accept", {s0.waitrequest, s1.waitrequest}, 2'b10);
        wait_drain("stall_drain");

        // Readdatavalid with an empty FIFO.
        @(negedge clk); inj = 1'b1;
        @(negedge clk); inj = 1'b0;
        chk("err_no_rdv", {s0.readdatavalid, s1.readdatavalid}, 2'b00);
        @(negedge clk);
        chk("err_flag", rd_err, 1);
        repeat (5) @(negedge clk);
        chk("err_sticky", rd_err, 1);

        // mem_ready drops mid-GNT0: the write completes, nothing else is granted.
        m.waitrequest = 1'b1;
        issue(mk(0, 0, 27'h210, 32'hA000_0210, 4'hF));
        exp_cmd.push_back(mk(0, 0, 27'h210, 32'hA000_0210, 4'hF));
        t = 0;
        while (!m.write && t < 20) begin @(negedge clk); t++; end
        chk("mr_grant", m.write, 1);
        issue(mk(1, 0, 27'h310, 32'hB000_0310, 4'hF));
        @(posedge clk); #1;
        mem_ready = 1'b0;
        m.waitrequest = 1'b0;
        @(negedge clk);
        chk("mr_complete", {s0.waitrequest, m.write}, 2'b01);
        repeat (6) begin
            @(negedge clk);
            chk("mr_no_grant", {m.read, m.write, s1.waitrequest}, 3'b001);
        end
        exp_cmd.push_back(mk(1, 0, 27'h310, 32'hB000_0310, 4'hF));
        mem_ready = 1'b1;
        wait_drain("mr_drain");

        chk("end_rderr", rd_err, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
